// File: rtl/wb_result_pipe.sv
// ---------------------------------------------------------------------------
// wb_result_pipe
//
// Carries each instruction's write-back tag (destination register, write
// enable, result source select) and its result data from ID through the
// EXE, MEM and WB stages, then drives the register-file write port. Every
// exe_*, mem_* and wb_* signal used by the operand-bypass (forwarding)
// logic originates here.
//
// Optional feature macro: WB_RETIRE_CNT_EN
//   When defined, adds output retire_cnt[31:0], a free-running count of
//   register writes retired from WB (wraps at 2^32).
//
// Parameters
//   DATA_W  result width
//   ADDR_W  register address width
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   hold                freeze every stage (memory wait)
//   id_bubble           inject a NOP into EXE instead of the ID instruction
//   id_write_addr       destination register decoded in ID
//   id_reg_write        ID instruction writes a register
//   id_movsrc           ID result comes from the move/immediate path
//   id_DM_read          ID instruction is a load
//   id_mov_data         move/immediate value formed in ID
//   exe_alu_result      combinational ALU output for the EXE instruction
//   mem_rdata           data-memory read data for the MEM instruction
//   exe_*               EXE-stage tag, mov data and ALU pass-through
//   mem_*               MEM-stage tag, ALU/mov data and read-data pass-through
//   wb_*                WB-stage tag and selected result
//   rf_we/waddr/wdata   register-file write port (combinational from WB)
//   retire_cnt          (WB_RETIRE_CNT_EN only) retired-write counter
//
// Tag outputs of a stage are meaningful only while that stage's reg_write
// is 1; consumers must qualify them with it.
// ---------------------------------------------------------------------------
module wb_result_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              id_bubble,
  input  logic [ADDR_W-1:0] id_write_addr,
  input  logic              id_reg_write,
  input  logic              id_movsrc,
  input  logic              id_DM_read,
  input  logic [DATA_W-1:0] id_mov_data,
  input  logic [DATA_W-1:0] exe_alu_result,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic [ADDR_W-1:0] exe_write_addr,
  output logic              exe_reg_write,
  output logic              exe_movsrc,
  output logic [DATA_W-1:0] exe_mov_data,
  output logic [DATA_W-1:0] exe_alu_data,

  output logic [ADDR_W-1:0] mem_write_addr,
  output logic              mem_reg_write,
  output logic              mem_DM_read,
  output logic              mem_movsrc,
  output logic [DATA_W-1:0] mem_alu_data,
  output logic [DATA_W-1:0] mem_mov_data,
  output logic [DATA_W-1:0] mem_data,

  output logic [ADDR_W-1:0] wb_write_addr,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] wb_data,

  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  // Write-back source select: a load takes memory data, a move takes the
  // move/immediate value, anything else takes the ALU result.
  function automatic logic [DATA_W-1:0] sel_wb_data(
    input logic              dm_read,
    input logic              movsrc,
    input logic [DATA_W-1:0] rdata,
    input logic [DATA_W-1:0] mov_data,
    input logic [DATA_W-1:0] alu_data
  );
    if (dm_read)     return rdata;
    else if (movsrc) return mov_data;
    else             return alu_data;
  endfunction

  // EXE stage state
  logic [ADDR_W-1:0] exe_addr_q,  exe_addr_d;
  logic              exe_rw_q,    exe_rw_d;
  logic              exe_mov_q,   exe_mov_d;
  logic              exe_dm_q,    exe_dm_d;
  logic [DATA_W-1:0] exe_movd_q,  exe_movd_d;

  // MEM stage state
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic              mem_rw_q,    mem_rw_d;
  logic              mem_mov_q,   mem_mov_d;
  logic              mem_dm_q,    mem_dm_d;
  logic [DATA_W-1:0] mem_alu_q,   mem_alu_d;
  logic [DATA_W-1:0] mem_movd_q,  mem_movd_d;

  // WB stage state
  logic [ADDR_W-1:0] wb_addr_q,   wb_addr_d;
  logic              wb_rw_q,     wb_rw_d;
  logic [DATA_W-1:0] wb_data_q,   wb_data_d;

  // -------------------------------------------------------------------------
  // ID -> EXE
  // -------------------------------------------------------------------------
  always_comb begin
    exe_addr_d = exe_addr_q;
    exe_rw_d   = exe_rw_q;
    exe_mov_d  = exe_mov_q;
    exe_dm_d   = exe_dm_q;
    exe_movd_d = exe_movd_q;
    if (!hold) begin
      if (id_bubble) begin
        // A bubble is a clean NOP: every field zero, not just the enables.
        exe_addr_d = '0;
        exe_rw_d   = 1'b0;
        exe_mov_d  = 1'b0;
        exe_dm_d   = 1'b0;
        exe_movd_d = '0;
      end else begin
        exe_addr_d = id_write_addr;
        exe_rw_d   = id_reg_write;
        exe_mov_d  = id_movsrc;
        exe_dm_d   = id_DM_read;
        exe_movd_d = id_mov_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // EXE -> MEM
  // -------------------------------------------------------------------------
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_rw_d   = mem_rw_q;
    mem_mov_d  = mem_mov_q;
    mem_dm_d   = mem_dm_q;
    mem_alu_d  = mem_alu_q;
    mem_movd_d = mem_movd_q;
    if (!hold) begin
      mem_addr_d = exe_addr_q;
      mem_rw_d   = exe_rw_q;
      mem_mov_d  = exe_mov_q;
      mem_dm_d   = exe_dm_q;
      mem_alu_d  = exe_alu_result;
      mem_movd_d = exe_movd_q;
    end
  end

  // -------------------------------------------------------------------------
  // MEM -> WB
  // -------------------------------------------------------------------------
  always_comb begin
    wb_addr_d = wb_addr_q;
    wb_rw_d   = wb_rw_q;
    wb_data_d = wb_data_q;
    if (!hold) begin
      wb_addr_d = mem_addr_q;
      wb_rw_d   = mem_rw_q;
      wb_data_d = sel_wb_data(mem_dm_q, mem_mov_q, mem_rdata,
                              mem_movd_q, mem_alu_q);
    end
  end

  // Reset clears data as well as control so a flushed pipe reads all zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_addr_q <= '0;
      exe_rw_q   <= 1'b0;
      exe_mov_q  <= 1'b0;
      exe_dm_q   <= 1'b0;
      exe_movd_q <= '0;
      mem_addr_q <= '0;
      mem_rw_q   <= 1'b0;
      mem_mov_q  <= 1'b0;
      mem_dm_q   <= 1'b0;
      mem_alu_q  <= '0;
      mem_movd_q <= '0;
      wb_addr_q  <= '0;
      wb_rw_q    <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      exe_addr_q <= exe_addr_d;
      exe_rw_q   <= exe_rw_d;
      exe_mov_q  <= exe_mov_d;
      exe_dm_q   <= exe_dm_d;
      exe_movd_q <= exe_movd_d;
      mem_addr_q <= mem_addr_d;
      mem_rw_q   <= mem_rw_d;
      mem_mov_q  <= mem_mov_d;
      mem_dm_q   <= mem_dm_d;
      mem_alu_q  <= mem_alu_d;
      mem_movd_q <= mem_movd_d;
      wb_addr_q  <= wb_addr_d;
      wb_rw_q    <= wb_rw_d;
      wb_data_q  <= wb_data_d;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  // Counts a retirement on every advancing edge that carries a write out of
  // WB; a held write is counted only once, when it finally leaves.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (!hold && wb_rw_q) retire_cnt_d = retire_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) retire_cnt_q <= '0;
    else     retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

  // Outputs
  assign exe_write_addr = exe_addr_q;
  assign exe_reg_write  = exe_rw_q;
  assign exe_movsrc     = exe_mov_q;
  assign exe_mov_data   = exe_movd_q;
  assign exe_alu_data   = exe_alu_result;

  assign mem_write_addr = mem_addr_q;
  assign mem_reg_write  = mem_rw_q;
  assign mem_DM_read    = mem_dm_q;
  assign mem_movsrc     = mem_mov_q;
  assign mem_alu_data   = mem_alu_q;
  assign mem_mov_data   = mem_movd_q;
  assign mem_data       = mem_rdata;

  assign wb_write_addr  = wb_addr_q;
  assign wb_reg_write   = wb_rw_q;
  assign wb_data        = wb_data_q;

  // The write port stays enabled under hold; rewriting the same value is
  // harmless.
  assign rf_we    = wb_rw_q;
  assign rf_waddr = wb_addr_q;
  assign rf_wdata = wb_data_q;

endmodule

// File: tb/tb_wb_result_pipe.sv
module tb_wb_result_pipe;

  logic        clk = 1'b0;
  logic        rst, hold, id_bubble;
  logic [4:0]  id_write_addr;
  logic        id_reg_write, id_movsrc, id_DM_read;
  logic [31:0] id_mov_data, exe_alu_result, mem_rdata;

  logic [4:0]  exe_write_addr, mem_write_addr, wb_write_addr, rf_waddr;
  logic        exe_reg_write, exe_movsrc;
  logic        mem_reg_write, mem_DM_read, mem_movsrc;
  logic        wb_reg_write, rf_we;
  logic [31:0] exe_mov_data, exe_alu_data;
  logic [31:0] mem_alu_data, mem_mov_data, mem_data;
  logic [31:0] wb_data, rf_wdata;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_result_pipe #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .hold(hold), .id_bubble(id_bubble),
    .id_write_addr(id_write_addr), .id_reg_write(id_reg_write),
    .id_movsrc(id_movsrc), .id_DM_read(id_DM_read),
    .id_mov_data(id_mov_data), .exe_alu_result(exe_alu_result),
    .mem_rdata(mem_rdata),
    .exe_write_addr(exe_write_addr), .exe_reg_write(exe_reg_write),
    .exe_movsrc(exe_movsrc), .exe_mov_data(exe_mov_data),
    .exe_alu_data(exe_alu_data),
    .mem_write_addr(mem_write_addr), .mem_reg_write(mem_reg_write),
    .mem_DM_read(mem_DM_read), .mem_movsrc(mem_movsrc),
    .mem_alu_data(mem_alu_data), .mem_mov_data(mem_mov_data),
    .mem_data(mem_data),
    .wb_write_addr(wb_write_addr), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  // Reference model: the history of instructions in the order they entered
  // EXE. After any number of advances, the newest entry is in EXE, the one
  // before it in MEM and the one before that in WB. Each entry also records
  // the ALU value seen while it left EXE and the read data seen while it
  // left MEM. Reset appends three all-zero entries.
  typedef struct {
    logic [4:0]  addr;
    logic        rw, mov, dm;
    logic [31:0] movd, alu, rd;
  } rec_t;

  rec_t        hist[$];
  rec_t        zero_rec = '{addr: 5'd0, rw: 1'b0, mov: 1'b0, dm: 1'b0,
                            movd: 32'd0, alu: 32'd0, rd: 32'd0};
  logic [31:0] model_cnt = 32'd0;

  function automatic logic [31:0] result_of(input rec_t r);
    if (r.dm)       return r.rd;
    else if (r.mov) return r.movd;
    else            return r.alu;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int   n;
    rec_t e, m, w;
    n = hist.size();
    e = hist[n-1];
    m = hist[n-2];
    w = hist[n-3];
    chk("exe_write_addr", {27'd0, exe_write_addr}, {27'd0, e.addr});
    chk("exe_reg_write",  {31'd0, exe_reg_write},  {31'd0, e.rw});
    chk("exe_movsrc",     {31'd0, exe_movsrc},     {31'd0, e.mov});
    chk("exe_mov_data",   exe_mov_data,            e.movd);
    chk("mem_write_addr", {27'd0, mem_write_addr}, {27'd0, m.addr});
    chk("mem_reg_write",  {31'd0, mem_reg_write},  {31'd0, m.rw});
    chk("mem_DM_read",    {31'd0, mem_DM_read},    {31'd0, m.dm});
    chk("mem_movsrc",     {31'd0, mem_movsrc},     {31'd0, m.mov});
    chk("mem_alu_data",   mem_alu_data,            m.alu);
    chk("mem_mov_data",   mem_mov_data,            m.movd);
    chk("wb_write_addr",  {27'd0, wb_write_addr},  {27'd0, w.addr});
    chk("wb_reg_write",   {31'd0, wb_reg_write},   {31'd0, w.rw});
    chk("wb_data",        wb_data,                 result_of(w));
    chk("rf_we",          {31'd0, rf_we},          {31'd0, w.rw});
    chk("rf_waddr",       {27'd0, rf_waddr},       {27'd0, w.addr});
    chk("rf_wdata",       rf_wdata,                result_of(w));
`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt",     retire_cnt,              model_cnt);
`endif
  endtask

  // One clock cycle: apply inputs, check the pass-throughs, take the edge,
  // update the model from the same inputs, then check every output.
  task automatic cyc(input logic r, input logic h, input logic b,
                     input logic [4:0] a, input logic w, input logic m,
                     input logic d, input logic [31:0] md,
                     input logic [31:0] al, input logic [31:0] rdv);
    int   n;
    rec_t t;
    rst = r; hold = h; id_bubble = b;
    id_write_addr = a; id_reg_write = w; id_movsrc = m; id_DM_read = d;
    id_mov_data = md; exe_alu_result = al; mem_rdata = rdv;
    #1;
    chk("exe_alu_data", exe_alu_data, al);
    chk("mem_data",     mem_data,     rdv);
    @(posedge clk);
    if (r) begin
      repeat (3) hist.push_back(zero_rec);
      model_cnt = 32'd0;
    end else if (!h) begin
      n = hist.size();
      if (hist[n-3].rw) model_cnt = model_cnt + 32'd1;
      t = hist[n-1]; t.alu = al;  hist[n-1] = t;
      t = hist[n-2]; t.rd  = rdv; hist[n-2] = t;
      if (b) t = zero_rec;
      else t = '{addr: a, rw: w, mov: m, dm: d, movd: md,
                 alu: 32'd0, rd: 32'd0};
      hist.push_back(t);
    end
    #1;
    check_all();
  endtask

  // Idle cycle: no writing instruction, random data on the buses.
  task automatic nop();
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0,
        $urandom(), $urandom());
  endtask

  // Issue one instruction with random bus values.
  task automatic issue(input logic [4:0] a, input logic w, input logic m,
                       input logic d, input logic [31:0] md);
    cyc(1'b0, 1'b0, 1'b0, a, w, m, d, md, $urandom(), $urandom());
  endtask

  task automatic reset_pulse();
    cyc(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0,
        $urandom(), $urandom());
  endtask

  initial begin
    // Reset from power-up.
    reset_pulse();
    reset_pulse();
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);

    // Reset flush: fill every stage with writes, then reset (even under hold).
    for (int i = 1; i <= 4; i++) issue(5'(i), 1'b1, 1'b0, 1'b0, $urandom());
    cyc(1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0,
        $urandom(), $urandom());
    chk("flush_exe_rw", {31'd0, exe_reg_write}, 32'd0);
    chk("flush_mem_rw", {31'd0, mem_reg_write}, 32'd0);
    chk("flush_wb_rw",  {31'd0, wb_reg_write},  32'd0);
    chk("flush_wb_data", wb_data, 32'd0);
    chk("flush_rf_we",  {31'd0, rf_we}, 32'd0);

    // ALU result path.
    issue(5'd3, 1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0,
        32'h0000_1234, $urandom());
    nop();
    chk("alu_rf_we",    {31'd0, rf_we}, 32'd1);
    chk("alu_rf_waddr", {27'd0, rf_waddr}, 32'd3);
    chk("alu_rf_wdata", rf_wdata, 32'h0000_1234);

    // Load path.
    issue(5'd7, 1'b1, 1'b0, 1'b1, 32'd0);
    nop();
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0,
        $urandom(), 32'hDEAD_BEEF);
    chk("load_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("load_wb_addr", {27'd0, wb_write_addr}, 32'd7);

    // Move path.
    issue(5'd12, 1'b1, 1'b1, 1'b0, 32'h55);
    chk("mov_exe", exe_mov_data, 32'h55);
    nop();
    chk("mov_mem", mem_mov_data, 32'h55);
    nop();
    chk("mov_wb", wb_data, 32'h55);

    // Bubble overrides a writing ID instruction.
    cyc(1'b0, 1'b0, 1'b1, 5'd20, 1'b1, 1'b1, 1'b1, 32'hABCD,
        $urandom(), $urandom());
    chk("bubble_exe_rw", {31'd0, exe_reg_write}, 32'd0);

    // Hold for two cycles with a full pipe; hold dominates bubble.
    issue(5'd1, 1'b1, 1'b0, 1'b0, 32'h11);
    issue(5'd2, 1'b1, 1'b1, 1'b0, 32'h22);
    issue(5'd3, 1'b1, 1'b0, 1'b1, 32'h33);
    cyc(1'b0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 32'h44,
        $urandom(), $urandom());
    cyc(1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h55,
        $urandom(), $urandom());
    chk("hold_wb_addr", {27'd0, wb_write_addr}, 32'd1);
    chk("hold_exe_addr", {27'd0, exe_write_addr}, 32'd3);
    for (int i = 0; i < 3; i++) nop();

    // Randomized traffic, including consecutive same destinations.
    for (int i = 0; i < 400; i++) begin
      logic        r, h, b, w, m, d;
      logic [4:0]  a;
      r = ($urandom_range(0, 49) == 0);
      h = ($urandom_range(0, 4) == 0);
      b = ($urandom_range(0, 6) == 0);
      w = ($urandom_range(0, 3) != 0);
      m = $urandom_range(0, 1) == 1;
      d = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 3) == 0) ? 5'd9 : 5'($urandom());
      cyc(r, h, b, a, w, m, d, $urandom(), $urandom(), $urandom());
    end

`ifdef WB_RETIRE_CNT_EN
    // Retire count: five writes and two bubbles, then drain.
    reset_pulse();
    for (int i = 0; i < 7; i++) begin
      if (i == 2 || i == 5)
        cyc(1'b0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 32'd0,
            $urandom(), $urandom());
      else
        issue(5'(i + 1), 1'b1, 1'b0, 1'b0, $urandom());
    end
    for (int i = 0; i < 4; i++) nop();
    chk("retire_cnt_5", retire_cnt, 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_result_pipe.md
# wb_result_pipe

Destination-tracking pipeline that carries each instruction's write-back tag (destination register, write enable, result source select) and result data from ID through EXE, MEM and WB, then drives the register-file write port. It is the producing end of the operand-bypass interface: every `exe_*`, `mem_*` and `wb_*` signal consumed by `forwarding` originates here. It sits beside the ID/EXE, EXE/MEM and MEM/WB pipeline registers and replaces their write-back fields.

## Interface
- `DATA_W`, 32, result width (matches `RegBus`)
- `ADDR_W`, 5, register address width (matches `RegAddrBus`)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `hold`  in  1  freeze all stages (memory wait)
- `id_bubble`  in  1  insert NOP into EXE (load-use or branch stall)
- `id_write_addr`  in  ADDR_W  destination register decoded in ID
- `id_reg_write`  in  1  ID instruction writes a register
- `id_movsrc`  in  1  result comes from move path (`MvRegSrc`)
- `id_DM_read`  in  1  ID instruction is a load
- `id_mov_data`  in  DATA_W  move/immediate value formed in ID
- `exe_alu_result`  in  DATA_W  combinational ALU output in EXE
- `mem_rdata`  in  DATA_W  data-memory read data, valid in MEM
- `exe_write_addr`, `exe_reg_write`, `exe_movsrc`, `exe_mov_data`  out  ADDR_W/1/1/DATA_W  EXE-stage tag
- `exe_alu_data`  out  DATA_W  pass-through of `exe_alu_result`
- `mem_write_addr`, `mem_reg_write`, `mem_DM_read`, `mem_movsrc`  out  ADDR_W/1/1/1  MEM-stage tag
- `mem_alu_data`, `mem_mov_data`, `mem_data`  out  DATA_W  MEM-stage results; `mem_data` passes through `mem_rdata`
- `wb_write_addr`, `wb_reg_write`, `wb_data`  out  ADDR_W/1/DATA_W  WB-stage tag and selected result
- `rf_we`, `rf_waddr`, `rf_wdata`  out  1/ADDR_W/DATA_W  register-file write port

Clock is `clk`; reset `rst` is synchronous and active-high.

## Operation
- Three register stages: EXE, MEM, WB. Each holds addr, reg_write, movsrc, DM_read, and the data fields it needs.
- Advance on every `clk` edge when `hold`=0:
  - EXE <= ID tag. If `id_bubble`=1, EXE.reg_write and EXE.DM_read are 0 and the other fields are don't-care, forced to 0.
  - MEM <= EXE tag, `mem_alu_data` <= `exe_alu_result`, `mem_mov_data` <= `exe_mov_data`.
  - WB <= MEM tag. `wb_data` <= `mem_rdata` if MEM.DM_read, else `mem_mov_data` if MEM.movsrc, else `mem_alu_data`.
- `hold`=1: all stages keep their values. `hold` dominates `id_bubble`.
- Register-file port is combinational from WB: `rf_we`=`wb_reg_write`, `rf_waddr`=`wb_write_addr`, `rf_wdata`=`wb_data`. `rf_we` is asserted while `hold`=1 too; the rewrite is idempotent.
- The tag outputs of a stage are invalid whenever that stage's reg_write is 0. Consumers must qualify them with it.

## Timing
- Reset (`rst`=1 at an edge): every stage register is set to 0, so all `*_reg_write`, `*_DM_read`, `*_movsrc`, addresses and data outputs read 0. `rst` overrides `hold`.
- Latency: ID tag to `exe_*` is 1 cycle, to `mem_*` 2 cycles, to `wb_*`/`rf_*` 3 cycles.
- Pass-through outputs (`exe_alu_data`, `mem_data`) have zero latency.
- Same destination in consecutive instructions: each stage carries its own copy, with no merging. Priority resolution is the consumer's job.
- Reset asserted mid-pipeline: in-flight writes are discarded and `rf_we` is 0 from the cycle after the reset edge.

## Configuration
- `WB_RETIRE_CNT_EN`:
  - Defined: adds output `retire_cnt` (32 bits). It resets to 0 and increments by 1 on each edge where `hold`=0 and WB.reg_write=1; it wraps from 0xFFFFFFFF to 0.
  - Undefined: the port and counter are absent.

## Test plan
- Reset flush: fill all stages with `reg_write`=1, then pulse `rst`. Next cycle all `*_reg_write`=0, `wb_data`=0 and `rf_we`=0.
- ALU result path: ID addr=3, reg_write=1, `exe_alu_result`=0x1234 in the EXE cycle. After 3 cycles `rf_we`=1, `rf_waddr`=3, `rf_wdata`=0x1234.
- Load path: ID addr=7, DM_read=1, `mem_rdata`=0xDEADBEEF in the MEM cycle. `wb_data`=0xDEADBEEF and `wb_write_addr`=7 one cycle later.
- Move path: movsrc=1, `id_mov_data`=0x55. `exe_mov_data`=0x55 after 1 cycle, `mem_mov_data`=0x55 after 2, `wb_data`=0x55 after 3.
- Bubble and hold:
  - `id_bubble`=1 with ID reg_write=1 gives `exe_reg_write`=0 the next cycle.
  - `hold`=1 for 2 cycles with the pipeline full keeps all outputs unchanged for those 2 cycles, and the pipeline resumes in order afterwards.
- `WB_RETIRE_CNT_EN`: after 5 writing instructions and 2 bubbles have drained, `retire_cnt`=5. Preloading the counter near 0xFFFFFFFF shows the wrap to 0.
